// File: rtl/smc_drv.sv
// smc_drv: loads six transistor parameter sets, one beat per transistor,
// into the parallel inputs of an SMC block. It then waits SETTLE_CYC cycles
// for the block to settle, captures the block's result and holds it until
// downstream accepts it.
// Optional build macro SMC_DRV_CMP_EN adds the following: an expected-result
// input latched on the first beat, a mismatch flag, and a saturating error
// counter.
module smc_drv #(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [8:0] in_data,
    input  logic [1:0] in_mode,
    output logic       in_ready,
    output logic [2:0] W_0,
    output logic [2:0] V_GS_0,
    output logic [2:0] V_DS_0,
    output logic [2:0] W_1,
    output logic [2:0] V_GS_1,
    output logic [2:0] V_DS_1,
    output logic [2:0] W_2,
    output logic [2:0] V_GS_2,
    output logic [2:0] V_DS_2,
    output logic [2:0] W_3,
    output logic [2:0] V_GS_3,
    output logic [2:0] V_DS_3,
    output logic [2:0] W_4,
    output logic [2:0] V_GS_4,
    output logic [2:0] V_DS_4,
    output logic [2:0] W_5,
    output logic [2:0] V_GS_5,
    output logic [2:0] V_DS_5,
    output logic [1:0] mode,
    input  logic [9:0] smc_out_n,
    output logic       out_valid,
    output logic [9:0] out_n,
    input  logic       out_ready
`ifdef SMC_DRV_CMP_EN
    ,
    input  logic [9:0] exp_n,
    output logic       mismatch,
    output logic [7:0] err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Settle counter value at which the SMC result is considered stable.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t     state_q, state_d;
    logic [2:0] beat_q, beat_d;
    logic [3:0] settle_q, settle_d;
    logic [1:0] mode_q;
    logic [9:0] out_n_q;

    logic       beat_acc;
    logic [2:0] wr_idx;
    logic       capture;
    logic       out_hs;

    // A beat lands on transistor 0 from IDLE, otherwise on the beat counter.
    assign beat_acc = in_valid && in_ready;
    assign wr_idx   = (state_q == IDLE) ? 3'd0 : beat_q;
    assign capture  = (state_q == SETTLE) && (settle_q == SETTLE_LAST);
    assign out_hs   = out_valid && out_ready;

    // State and counter registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= 3'd0;
            settle_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            settle_q <= settle_d;
        end
    end

    // Next-state logic: load six beats, settle, then hold until accepted.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        settle_d = settle_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    beat_d  = 3'd1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd5) begin
                        settle_d = 4'd0;
                        state_d  = SETTLE;
                    end
                end
            end
            SETTLE: begin
                settle_d = settle_q + 4'd1;
                if (settle_q == SETTLE_LAST) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: accept beats only while loading, result valid in HOLD.
    always_comb begin
        in_ready  = (state_q == IDLE) || (state_q == LOAD);
        out_valid = (state_q == HOLD);
    end

    // One parameter register per transistor, written only by its own beat.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_xtor
            logic [8:0] xtor_q;
            // Capture this transistor's {W, V_GS, V_DS} on its beat.
            always_ff @(posedge clk) begin
                if (rst) begin
                    xtor_q <= 9'd0;
                end else if (beat_acc && (wr_idx == 3'(gi))) begin
                    xtor_q <= in_data;
                end
            end
        end
    endgenerate

    assign W_0    = g_xtor[0].xtor_q[8:6];
    assign V_GS_0 = g_xtor[0].xtor_q[5:3];
    assign V_DS_0 = g_xtor[0].xtor_q[2:0];
    assign W_1    = g_xtor[1].xtor_q[8:6];
    assign V_GS_1 = g_xtor[1].xtor_q[5:3];
    assign V_DS_1 = g_xtor[1].xtor_q[2:0];
    assign W_2    = g_xtor[2].xtor_q[8:6];
    assign V_GS_2 = g_xtor[2].xtor_q[5:3];
    assign V_DS_2 = g_xtor[2].xtor_q[2:0];
    assign W_3    = g_xtor[3].xtor_q[8:6];
    assign V_GS_3 = g_xtor[3].xtor_q[5:3];
    assign V_DS_3 = g_xtor[3].xtor_q[2:0];
    assign W_4    = g_xtor[4].xtor_q[8:6];
    assign V_GS_4 = g_xtor[4].xtor_q[5:3];
    assign V_DS_4 = g_xtor[4].xtor_q[2:0];
    assign W_5    = g_xtor[5].xtor_q[8:6];
    assign V_GS_5 = g_xtor[5].xtor_q[5:3];
    assign V_DS_5 = g_xtor[5].xtor_q[2:0];

    // Mode is taken from the first beat only, and the result from the last settle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= 2'd0;
            out_n_q <= 10'd0;
        end else begin
            if (beat_acc && (state_q == IDLE)) begin
                mode_q <= in_mode;
            end
            if (capture) begin
                out_n_q <= smc_out_n;
            end
        end
    end

    assign mode  = mode_q;
    assign out_n = out_n_q;

`ifdef SMC_DRV_CMP_EN
    logic [9:0] exp_q;
    logic [7:0] err_q;

    // Latch the expected result with the first beat; count mismatching handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q <= 10'd0;
            err_q <= 8'd0;
        end else begin
            if (beat_acc && (state_q == IDLE)) begin
                exp_q <= exp_n;
            end
            if (out_hs && mismatch && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign mismatch = out_valid && (out_n_q != exp_q);
    assign err_cnt  = err_q;
`else
    // The handshake is only needed by the comparison logic.
    logic unused_hs;
    assign unused_hs = out_hs;
`endif

endmodule

// File: tb/tb_smc_drv.sv
// Scoreboard bench for smc_drv. Each transaction pushes its expected
// parallel drive and result when it is issued. The entry is popped and
// compared at the output handshake.
module tb_smc_drv;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [8:0] in_data;
    logic [1:0] in_mode;
    logic       in_ready;
    logic [2:0] W_0, V_GS_0, V_DS_0, W_1, V_GS_1, V_DS_1, W_2, V_GS_2, V_DS_2;
    logic [2:0] W_3, V_GS_3, V_DS_3, W_4, V_GS_4, V_DS_4, W_5, V_GS_5, V_DS_5;
    logic [1:0] mode;
    logic [9:0] smc_out_n;
    logic       out_valid;
    logic [9:0] out_n;
    logic       out_ready;
`ifdef SMC_DRV_CMP_EN
    logic [9:0] exp_n;
    logic       mismatch;
    logic [7:0] err_cnt;
`endif

    smc_drv #(.SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_mode(in_mode), .in_ready(in_ready),
        .W_0(W_0), .V_GS_0(V_GS_0), .V_DS_0(V_DS_0),
        .W_1(W_1), .V_GS_1(V_GS_1), .V_DS_1(V_DS_1),
        .W_2(W_2), .V_GS_2(V_GS_2), .V_DS_2(V_DS_2),
        .W_3(W_3), .V_GS_3(V_GS_3), .V_DS_3(V_DS_3),
        .W_4(W_4), .V_GS_4(V_GS_4), .V_DS_4(V_DS_4),
        .W_5(W_5), .V_GS_5(V_GS_5), .V_DS_5(V_DS_5),
        .mode(mode), .smc_out_n(smc_out_n),
        .out_valid(out_valid), .out_n(out_n), .out_ready(out_ready)
`ifdef SMC_DRV_CMP_EN
        , .exp_n(exp_n), .mismatch(mismatch), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int txn_n = 0;

    typedef struct {
        logic [55:0] par;
        logic [9:0]  n;
    } exp_t;

    exp_t sb[$];

    // Whole parallel drive as one word: transistor 5 down to 0, then mode.
    function automatic logic [55:0] par_now();
        return {W_5, V_GS_5, V_DS_5, W_4, V_GS_4, V_DS_4, W_3, V_GS_3, V_DS_3,
                W_2, V_GS_2, V_DS_2, W_1, V_GS_1, V_DS_1, W_0, V_GS_0, V_DS_0, mode};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one full transaction and retire it through the scoreboard.
    task automatic run_txn(input logic [5:0][8:0] beats, input logic [1:0] md,
                           input int gap, input logic [9:0] smc_val, input int hold,
                           input bit poke, input logic [9:0] expn);
        exp_t e;
        exp_t got;
        int   lat;
        e.par = {beats, md};
        e.n   = smc_val;
        sb.push_back(e);
        smc_out_n = ~smc_val;
`ifdef SMC_DRV_CMP_EN
        exp_n = expn;
`else
        if (expn != smc_val) $display("note: expected-result input unused in this build");
`endif
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = beats[k];
            in_mode  = (k == 0) ? md : ~md;
            chk("load_ready", {63'd0, in_ready}, 64'd1);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 9'h1FF;
            if (k < 5) begin
                for (int g = 0; g < gap; g++) begin
                    chk("stall_ready", {63'd0, in_ready}, 64'd1);
                    @(negedge clk);
                end
            end
        end
        // Result is only meaningful from the edge that accepted the last beat on.
        smc_out_n = smc_val;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(SETTLE));
        smc_out_n = ~smc_val;
        if (poke) begin
            in_valid = 1'b1;
            in_data  = 9'h1FF;
            in_mode  = ~md;
        end
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_n", {54'd0, out_n}, {54'd0, e.n});
            chk("hold_ready", {63'd0, in_ready}, 64'd0);
            chk("hold_par", {8'd0, par_now()}, {8'd0, e.par});
            @(negedge clk);
        end
`ifdef SMC_DRV_CMP_EN
        chk("mismatch", {63'd0, mismatch}, {63'd0, (smc_val != expn)});
`endif
        out_ready = 1'b1;
        if (out_valid === 1'b1 && sb.size() > 0) begin
            got = sb.pop_front();
            chk("out_n", {54'd0, out_n}, {54'd0, got.n});
            chk("par", {8'd0, par_now()}, {8'd0, got.par});
            txn_n++;
            $display("txn %0d: mode=%0d out_n=0x%03h latency=%0d hold=%0d gap=%0d",
                     txn_n, md, out_n, lat, hold, gap);
        end else begin
            chk("hs_valid", {63'd0, out_valid}, 64'd1);
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("valid_drop", {63'd0, out_valid}, 64'd0);
        chk("idle_ready", {63'd0, in_ready}, 64'd1);
        chk("post_par", {8'd0, par_now()}, {8'd0, e.par});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0][8:0] ba;
        logic [5:0][8:0] br;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 9'h000;
        in_mode   = 2'd0;
        out_ready = 1'b0;
        smc_out_n = 10'h000;
`ifdef SMC_DRV_CMP_EN
        exp_n = 10'h000;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_par", {8'd0, par_now()}, 64'd0);
        chk("rst_out_n", {54'd0, out_n}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
`ifdef SMC_DRV_CMP_EN
        chk("rst_mismatch", {63'd0, mismatch}, 64'd0);
        chk("rst_err_cnt", {56'd0, err_cnt}, 64'd0);
`endif

        // Beats 0x049, 0x092, ... 0x1B6: every field of transistor k equals k+1.
        ba[0] = 9'h049; ba[1] = 9'h092; ba[2] = 9'h0DB;
        ba[3] = 9'h124; ba[4] = 9'h16D; ba[5] = 9'h1B6;
        run_txn(ba, 2'd2, 0, 10'h155, 0, 1'b0, 10'h155);
        chk("W_0", {61'd0, W_0}, 64'd1);
        chk("V_DS_3", {61'd0, V_DS_3}, 64'd4);
        chk("W_5", {61'd0, W_5}, 64'd6);
        chk("mode", {62'd0, mode}, 64'd2);

        // Same beats with 3-cycle gaps, long hold and a stray beat during HOLD.
        run_txn(ba, 2'd1, 3, 10'h2A5, 5, 1'b1, 10'h2A5);

        // Abort a partial load with reset, with reset colliding with a beat.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 9'h0AA + 9'(k);
            in_mode  = 2'd3;
            @(posedge clk);
            @(negedge clk);
        end
        rst     = 1'b1;
        in_data = 9'h1FF;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("abort_par", {8'd0, par_now()}, 64'd0);
        chk("abort_out_n", {54'd0, out_n}, 64'd0);
        chk("abort_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_ready", {63'd0, in_ready}, 64'd1);

        for (int t = 0; t < 4; t++) begin
            logic [9:0] sv;
            for (int k = 0; k < 6; k++) br[k] = 9'($urandom_range(0, 511));
            sv = 10'($urandom_range(0, 1023));
            run_txn(br, 2'($urandom_range(0, 3)), (t == 0) ? 1 : int'($urandom_range(0, 2)),
                    sv, int'($urandom_range(0, 3)), t[0], sv);
        end

`ifdef SMC_DRV_CMP_EN
        chk("err_before", {56'd0, err_cnt}, 64'd0);
        run_txn(ba, 2'd0, 0, 10'h101, 1, 1'b0, 10'h100);
        run_txn(ba, 2'd3, 1, 10'h101, 2, 1'b0, 10'h100);
        chk("err_after", {56'd0, err_cnt}, 64'd2);
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
